// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: timed phases, pause/door handling,
// actuator decode and a seconds-remaining countdown.
module wash_sequencer #(
   parameter int TICK    = 100000000,
   parameter int FILL_S  = 3,
   parameter int WASH_S  = 4,
   parameter int RINSE_S = 3,
   parameter int DRAIN_S = 2,
   parameter int SPIN_S  = 4,
   parameter int DONE_S  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       on,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       pause_pos,
   input  logic       door_open,
   output logic [2:0] phase,
   output logic       paused,
   output logic       valve_on,
   output logic       motor_on,
   output logic       pump_on,
   output logic       door_lock,
   output logic [7:0] remain,
   output logic       done,
   output logic       buzz_req
);

   localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      DRAIN = 3'd4,
      SPIN  = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t        state;
   state_t        nxt_state;
   logic [1:0]    mode_q;
   logic [PW-1:0] presc;
   logic [7:0]    cnt;
   logic [7:0]    left;
   logic          running;
   logic          sec_tick;
   logic          last_sec;

   function automatic logic [7:0] dur(input state_t s, input logic [1:0] m);
      unique case (s)
         FILL:    dur = 8'(FILL_S);
         WASH:    dur = 8'(WASH_S * int'(m));
         RINSE:   dur = 8'(RINSE_S);
         DRAIN:   dur = 8'(DRAIN_S);
         SPIN:    dur = 8'(SPIN_S);
         DONE:    dur = 8'(DONE_S);
         default: dur = 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] total(input logic [1:0] m);
      if (m == 2'b00)
         total = 8'(DRAIN_S + SPIN_S);
      else
         total = 8'(FILL_S + WASH_S * int'(m) + RINSE_S + DRAIN_S + SPIN_S);
   endfunction

   always_comb begin
      nxt_state = IDLE;
      unique case (state)
         FILL:    nxt_state = WASH;
         WASH:    nxt_state = RINSE;
         RINSE:   nxt_state = DRAIN;
         DRAIN:   nxt_state = SPIN;
         SPIN:    nxt_state = DONE;
         default: nxt_state = IDLE;
      endcase
   end

   assign running  = (state inside {FILL, WASH, RINSE, DRAIN, SPIN});
   assign sec_tick = (state != IDLE) && !paused && (presc == PW'(TICK - 1));
   assign last_sec = sec_tick && (cnt == 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         mode_q <= 2'b00;
         presc  <= '0;
         cnt    <= 8'd0;
         left   <= 8'd0;
         paused <= 1'b0;
         done   <= 1'b0;
      end else if (!on) begin
         state  <= IDLE;
         presc  <= '0;
         cnt    <= 8'd0;
         left   <= 8'd0;
         paused <= 1'b0;
         done   <= 1'b0;
      end else if (state == IDLE) begin
         presc  <= '0;
         paused <= 1'b0;
         done   <= 1'b0;
         if (start && !door_open) begin
            mode_q <= mode;
            state  <= (mode == 2'b00) ? DRAIN : FILL;
            cnt    <= dur((mode == 2'b00) ? DRAIN : FILL, mode);
            left   <= total(mode);
         end
      end else begin
         done <= 1'b0;
         if (!paused)
            presc <= sec_tick ? '0 : presc + 1'b1;
         if (sec_tick && running)
            left <= left - 8'd1;
         if (last_sec) begin
            state <= nxt_state;
            cnt   <= dur(nxt_state, mode_q);
            if (nxt_state == DONE) begin
               done <= 1'b1;
               left <= 8'd0;
            end
         end else if (sec_tick) begin
            cnt <= cnt - 8'd1;
         end
         // Pause applies after any phase advance on the same edge
         if (paused) begin
            if (pause_pos && !door_open)
               paused <= 1'b0;
         end else if (pause_pos || (door_open && running)) begin
            paused <= 1'b1;
         end
         if (last_sec && state == DONE)
            paused <= 1'b0;
      end
   end

   assign phase     = state;
   assign remain    = left;
   assign door_lock = running;
   assign buzz_req  = (state == DONE);
   assign valve_on  = !paused && (state == FILL || state == RINSE);
   assign motor_on  = !paused && (state inside {WASH, RINSE, SPIN});
   assign pump_on   = !paused && (state == DRAIN || state == SPIN);

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed-vector bench for wash_sequencer with a fast tick (TICK=4).
module tb_wash_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       on;
   logic       start;
   logic [1:0] mode;
   logic       pause_pos;
   logic       door_open;
   logic [2:0] phase;
   logic       paused;
   logic       valve_on;
   logic       motor_on;
   logic       pump_on;
   logic       door_lock;
   logic [7:0] remain;
   logic       done;
   logic       buzz_req;

   int nvec = 0;
   int nerr = 0;
   int done_seen = 0;
   int valve_seen = 0;

   wash_sequencer #(.TICK(4)) dut (
      .clk(clk), .rst(rst), .on(on), .start(start), .mode(mode),
      .pause_pos(pause_pos), .door_open(door_open), .phase(phase),
      .paused(paused), .valve_on(valve_on), .motor_on(motor_on),
      .pump_on(pump_on), .door_lock(door_lock), .remain(remain),
      .done(done), .buzz_req(buzz_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
         if (valve_on) valve_seen++;
      end
   endtask

   task automatic run_phase(input string tag, input int p, input int len);
      int n = 0;
      while (phase == 3'(p) && n < 200) begin
         step(1);
         n++;
      end
      chk(tag, n, len);
   endtask

   task automatic go(input logic [1:0] m);
      mode = m;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_pause();
      pause_pos = 1'b1;
      step(1);
      pause_pos = 1'b0;
   endtask

   initial begin
      rst = 1'b1; on = 1'b0; start = 1'b0; mode = 2'b00;
      pause_pos = 1'b0; door_open = 1'b0;
      step(2);
      chk("rst_phase", phase, 0);
      chk("rst_remain", remain, 0);
      chk("rst_lock", door_lock, 0);
      chk("rst_paused", paused, 0);
      chk("rst_buzz", buzz_req, 0);
      rst = 1'b0; on = 1'b1;
      step(2);

      // mode 01 full program
      done_seen = 0;
      go(2'b01);
      chk("m1_phase", phase, 1);
      chk("m1_remain", remain, 16);
      chk("m1_valve", valve_on, 1);
      chk("m1_lock", door_lock, 1);
      run_phase("m1_fill", 1, 12);
      chk("m1_rem_wash", remain, 13);
      chk("m1_motor", motor_on, 1);
      run_phase("m1_wash", 2, 16);
      run_phase("m1_rinse", 3, 12);
      run_phase("m1_drain", 4, 8);
      chk("m1_pump", pump_on, 1);
      run_phase("m1_spin", 5, 16);
      chk("m1_rem_done", remain, 0);
      chk("m1_buzz", buzz_req, 1);
      chk("m1_lock_done", door_lock, 0);
      run_phase("m1_done", 6, 12);
      chk("m1_idle", phase, 0);
      chk("m1_done_cnt", done_seen, 1);

      // mode 00 spin-only
      valve_seen = 0;
      go(2'b00);
      chk("m0_phase", phase, 4);
      chk("m0_remain", remain, 6);
      run_phase("m0_drain", 4, 8);
      run_phase("m0_spin", 5, 16);
      run_phase("m0_done", 6, 12);
      chk("m0_valve", valve_seen, 0);

      // door opened during WASH
      go(2'b01);
      run_phase("dr_fill", 1, 12);
      step(2);
      door_open = 1'b1;
      step(1);
      chk("dr_paused", paused, 1);
      chk("dr_motor", motor_on, 0);
      chk("dr_phase", phase, 2);
      chk("dr_lock", door_lock, 1);
      chk("dr_remain", remain, 13);
      step(10);
      chk("dr_hold", remain, 13);
      pulse_pause();
      chk("dr_ignored", paused, 1);
      door_open = 1'b0;
      step(3);
      chk("dr_no_auto", paused, 1);
      pulse_pause();
      chk("dr_resume", paused, 0);
      chk("dr_motor_on", motor_on, 1);
      step(4);
      chk("dr_continue", remain, 12);
      rst = 1'b1;
      step(1);
      rst = 1'b0;

      // start with door open is ignored
      door_open = 1'b1;
      go(2'b01);
      chk("st_door", phase, 0);
      door_open = 1'b0;

      // start during SPIN, then pause on the final SPIN tick
      go(2'b00);
      run_phase("sp_drain", 4, 8);
      step(2);
      go(2'b11);
      chk("sp_start_phase", phase, 5);
      chk("sp_start_rem", remain, 4);
      step(12);
      done_seen = 0;
      pulse_pause();
      chk("sp_phase", phase, 6);
      chk("sp_paused", paused, 1);
      chk("sp_done", done, 1);
      chk("sp_buzz", buzz_req, 1);
      step(20);
      chk("sp_hold", phase, 6);
      chk("sp_one_done", done_seen, 1);
      pulse_pause();
      chk("sp_resume", paused, 0);
      done_seen = 0;
      run_phase("sp_done_len", 6, 12);
      chk("sp_no_redone", done_seen, 0);

      // async reset mid-RINSE
      go(2'b10);
      run_phase("rs_fill", 1, 12);
      run_phase("rs_wash", 2, 32);
      step(3);
      #3 rst = 1'b1;
      #1;
      chk("rs_phase", phase, 0);
      chk("rs_valve", valve_on, 0);
      chk("rs_motor", motor_on, 0);
      chk("rs_lock", door_lock, 0);
      chk("rs_remain", remain, 0);
      #1 rst = 1'b0;
      step(2);
      chk("rs_abandon", phase, 0);

      // power off mid-FILL
      go(2'b01);
      step(5);
      on = 1'b0;
      done_seen = 0;
      step(1);
      chk("off_phase", phase, 0);
      chk("off_remain", remain, 0);
      chk("off_valve", valve_on, 0);
      chk("off_lock", door_lock, 0);
      on = 1'b1;
      step(3);
      chk("off_stay", phase, 0);
      chk("off_no_done", done_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter TICK, default 100000000, clk cycles per second.
REQ-002 SHALL have parameters FILL_S=3, WASH_S=4, RINSE_S=3, DRAIN_S=2, SPIN_S=4, DONE_S=3; each is a phase duration in seconds, and WASH_S is per mode unit.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 on  input  1  machine power enable; low forces idle.
REQ-007 start  input  1  single-cycle pulse from billing (its next output); begins a program.
REQ-008 mode  input  2  00 spin-only, 01 small, 10 medium, 11 large.
REQ-009 pause_pos  input  1  single-cycle debounced button pulse; toggles pause.
REQ-010 door_open  input  1  level; high means the door is open.
REQ-011 phase  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, SPIN=5, DONE=6.
REQ-012 paused  output  1  high while a program is frozen.
REQ-013 valve_on, motor_on, pump_on, door_lock  output  1 each  actuator drives.
REQ-014 remain  output  8  unsigned binary seconds left in the whole program.
REQ-015 done  output  1  single-cycle pulse on entry to DONE.
REQ-016 buzz_req  output  1  high throughout DONE.

Function
REQ-017 A prescaler SHALL count 0..TICK-1 and issue sec_tick on the cycle it equals TICK-1; it SHALL be held at 0 in IDLE and frozen while paused.
REQ-018 In IDLE, a start that coincides with on=1 and door_open=0 SHALL latch mode and enter the first phase at that edge; start in any other state or condition SHALL be ignored.
REQ-019 Sequence for mode!=00 SHALL be FILL->WASH->RINSE->DRAIN->SPIN->DONE; for mode 00 it SHALL be DRAIN->SPIN->DONE.
REQ-020 WASH duration SHALL be WASH_S*mode_latched; every other phase lasts its parameter value.
REQ-021 Each phase SHALL load its duration on entry, decrement on each sec_tick, and advance on the sec_tick that finds the value 1, so every phase lasts exactly N seconds (N*TICK cycles).
REQ-022 remain SHALL load the program total at start, i.e. 12+4*mode for mode!=00 and 6 for mode 00, decrement on each sec_tick in running phases, and read 0 in DONE and IDLE.
REQ-023 Actuator decode SHALL be combinational from the state register, with no extra cycle of latency: FILL valve; WASH motor; RINSE valve+motor; DRAIN pump; SPIN motor+pump; all others none.
REQ-024 door_lock SHALL be 1 in FILL through SPIN, including while paused, and 0 in IDLE and DONE.
REQ-025 In a running phase, pause_pos SHALL set paused; a second pause_pos SHALL clear it only if door_open=0, and SHALL be ignored otherwise.
REQ-026 door_open=1 in a running phase SHALL set paused at that edge. Closing the door SHALL NOT auto-resume; a pause_pos is required.
REQ-027 While paused, valve_on, motor_on and pump_on SHALL be 0, and phase, remain and the prescaler SHALL hold.
REQ-028 If pause_pos and the final sec_tick of a phase coincide, the phase SHALL advance first and paused SHALL then be set in the new phase. The prescaler stays frozen from that edge.
REQ-029 DONE SHALL last DONE_S seconds with buzz_req=1, then return to IDLE. done SHALL pulse on the first DONE cycle only.
REQ-030 on=0 at any edge SHALL force IDLE synchronously, clear paused, clear the counters, and drop all outputs to 0. No done pulse occurs.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE with phase=0, paused=0, remain=0, all actuators 0, door_lock=0, done=0, buzz_req=0, and the prescaler and phase counters cleared.
REQ-032 Reset applied mid-program SHALL abandon the program; a new start is needed afterwards.

Verification (TICK=4)
REQ-033 mode=01, start -> FILL 12 cycles, WASH 16, RINSE 12, DRAIN 8, SPIN 16, DONE 12 with one done pulse; remain starts at 16 and reaches 0 at DONE.
REQ-034 mode=00, start -> phase goes 4 then 5 then 6; remain=6 at start; valve_on never asserts.
REQ-035 door_open=1 during WASH -> motor_on=0 and paused=1 that edge; remain frozen. pause_pos with the door still open is ignored. After the door closes, pause_pos resumes and remain continues from its held value.
REQ-036 start with door_open=1, or start during SPIN -> no state change.
REQ-037 pause_pos on the last SPIN sec_tick -> phase=6 and paused=1. DONE holds until pause_pos, then completes.
REQ-038 rst pulse mid-RINSE -> all outputs 0 immediately, before the next clk edge. on=0 mid-FILL -> IDLE at the next edge with no done pulse.
